// File: rtl/car_sequencer.sv
// Microsequencer driving the MSP430 control address register (CAR).
// Optional interrupt entry at decode points is compiled in with `CAR_SEQ_INT_EN.
module car_sequencer #(
  parameter int unsigned CAR_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic [15:0]         MDB,
  input  logic [3:0]          flags_nxt,
  input  logic                INT,
  input  logic                GIE,
  output logic [CAR_BITS-1:0] CAR,
  output logic                decode_pt,
  output logic                ILL
);

  typedef logic [CAR_BITS-1:0] car_t;

  // Chains occupy consecutive codes so that every non-final state simply increments.
  localparam car_t CAR_0           = car_t'(0);
  localparam car_t CAR_REG_REG     = car_t'(1);
  localparam car_t CAR_REG_IDX0    = car_t'(2);
  localparam car_t CAR_REG_IDX3    = car_t'(5);
  localparam car_t CAR_IND_REG0    = car_t'(6);
  localparam car_t CAR_IND_REG1    = car_t'(7);
  localparam car_t CAR_IND_IDX0    = car_t'(8);
  localparam car_t CAR_IND_IDX4    = car_t'(12);
  localparam car_t CAR_IDX_REG0    = car_t'(13);
  localparam car_t CAR_IDX_REG2    = car_t'(15);
  localparam car_t CAR_IDX_IDX0    = car_t'(16);
  localparam car_t CAR_IDX_IDX5    = car_t'(21);
  localparam car_t CAR_1OP_REG     = car_t'(22);
  localparam car_t CAR_1OP_IND0    = car_t'(23);
  localparam car_t CAR_1OP_IND2    = car_t'(25);
  localparam car_t CAR_1OP_IDX0    = car_t'(26);
  localparam car_t CAR_1OP_IDX3    = car_t'(29);
  localparam car_t CAR_PUSH_REG0   = car_t'(30);
  localparam car_t CAR_PUSH_REG2   = car_t'(32);
  localparam car_t CAR_PUSH_IND0   = car_t'(33);
  localparam car_t CAR_PUSH_IND2   = car_t'(35);
  localparam car_t CAR_PUSH_IDX0   = car_t'(36);
  localparam car_t CAR_PUSH_IDX3   = car_t'(39);
  localparam car_t CAR_CALL_REG0   = car_t'(40);
  localparam car_t CAR_CALL_REG2   = car_t'(42);
  localparam car_t CAR_CALL_IND0   = car_t'(43);
  localparam car_t CAR_CALL_IND2   = car_t'(45);
  localparam car_t CAR_CALL_IDX0   = car_t'(46);
  localparam car_t CAR_CALL_IDX3   = car_t'(49);
  localparam car_t CAR_RETI0       = car_t'(50);
  localparam car_t CAR_RETI3       = car_t'(53);
  localparam car_t CAR_INT0        = car_t'(54);
  localparam car_t CAR_INT4        = car_t'(58);
  localparam car_t CAR_JMP0        = car_t'(59);

  typedef enum logic [1:0] {ClsReg, ClsIdx, ClsInd} mode_cls_e;

  car_t      car_q, car_d;
  logic      ill_q, ill_d;
  logic      int_take;
  logic      is_fmt2;
  logic [3:0] src_r;
  logic [1:0] as_bits;
  mode_cls_e src_cls;
  logic      jmp_cond;
  car_t      dec_car;
  logic      dec_ill;
  logic      ret_zero;
  logic      unused_bits;

`ifdef CAR_SEQ_INT_EN
  assign int_take    = INT & GIE;
  assign unused_bits = MDB[6];
`else
  assign int_take    = 1'b0;
  assign unused_bits = MDB[6] ^ INT ^ GIE;
`endif

  assign CAR = car_q;
  assign ILL = ill_q;

  always_comb begin
    decode_pt = car_q inside {CAR_0, CAR_REG_REG, CAR_REG_IDX3, CAR_IND_REG1, CAR_IND_IDX4,
                              CAR_IDX_REG2, CAR_IDX_IDX5, CAR_1OP_REG, CAR_1OP_IND2,
                              CAR_1OP_IDX3, CAR_PUSH_REG2, CAR_PUSH_IND2, CAR_PUSH_IDX3};
  end

  always_comb begin
    ret_zero = car_q inside {CAR_CALL_REG2, CAR_CALL_IND2, CAR_CALL_IDX3, CAR_RETI3,
                             CAR_INT4, CAR_JMP0};
    if (car_q > CAR_JMP0) ret_zero = 1'b1;
`ifndef CAR_SEQ_INT_EN
    // Interrupt chain is unreachable in this build; treat it as unused encodings.
    if (car_q >= CAR_INT0 && car_q <= CAR_INT4) ret_zero = 1'b1;
`endif
  end

  // Source mode class; r2/r3 constant-generator forms behave as register operands.
  always_comb begin
    is_fmt2 = (MDB[15:12] == 4'b0001);
    src_r   = is_fmt2 ? MDB[3:0] : MDB[11:8];
    as_bits = MDB[5:4];
    if (as_bits == 2'b00 || src_r == 4'd3 || (src_r == 4'd2 && as_bits[1])) begin
      src_cls = ClsReg;
    end else if (as_bits == 2'b01) begin
      src_cls = ClsIdx;
    end else begin
      src_cls = ClsInd;
    end
  end

  // flags_nxt = {V, N, Z, C}
  always_comb begin
    unique case (MDB[12:10])
      3'b000:  jmp_cond = ~flags_nxt[1];
      3'b001:  jmp_cond = flags_nxt[1];
      3'b010:  jmp_cond = ~flags_nxt[0];
      3'b011:  jmp_cond = flags_nxt[0];
      3'b100:  jmp_cond = flags_nxt[2];
      3'b101:  jmp_cond = ~(flags_nxt[2] ^ flags_nxt[3]);
      3'b110:  jmp_cond = flags_nxt[2] ^ flags_nxt[3];
      default: jmp_cond = 1'b1;
    endcase
  end

  always_comb begin
    dec_car = CAR_0;
    dec_ill = 1'b0;
    if (int_take) begin
      dec_car = CAR_INT0;
    end else if (MDB[15:13] == 3'b001) begin
      dec_car = jmp_cond ? CAR_JMP0 : CAR_0;
    end else if (is_fmt2) begin
      unique case (MDB[9:7])
        3'b000, 3'b001, 3'b010, 3'b011: begin
          unique case (src_cls)
            ClsReg:  dec_car = CAR_1OP_REG;
            ClsIdx:  dec_car = CAR_1OP_IDX0;
            default: dec_car = CAR_1OP_IND0;
          endcase
        end
        3'b100: begin
          unique case (src_cls)
            ClsReg:  dec_car = CAR_PUSH_REG0;
            ClsIdx:  dec_car = CAR_PUSH_IDX0;
            default: dec_car = CAR_PUSH_IND0;
          endcase
        end
        3'b101: begin
          unique case (src_cls)
            ClsReg:  dec_car = CAR_CALL_REG0;
            ClsIdx:  dec_car = CAR_CALL_IDX0;
            default: dec_car = CAR_CALL_IND0;
          endcase
        end
        3'b110:  dec_car = CAR_RETI0;
        default: dec_ill = 1'b1;
      endcase
    end else if (MDB[15:14] != 2'b00) begin
      unique case (src_cls)
        ClsReg:  dec_car = MDB[7] ? CAR_REG_IDX0 : CAR_REG_REG;
        ClsIdx:  dec_car = MDB[7] ? CAR_IDX_IDX0 : CAR_IDX_REG0;
        default: dec_car = MDB[7] ? CAR_IND_IDX0 : CAR_IND_REG0;
      endcase
    end else begin
      dec_ill = 1'b1;
    end
  end

  always_comb begin
    car_d = car_q;
    ill_d = ill_q;
    if (!stall) begin
      ill_d = 1'b0;
      if (decode_pt) begin
        car_d = dec_car;
        ill_d = dec_ill;
      end else if (ret_zero) begin
        car_d = CAR_0;
      end else begin
        car_d = car_q + car_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_q <= CAR_0;
      ill_q <= 1'b0;
    end else begin
      car_q <= car_d;
      ill_q <= ill_d;
    end
  end

endmodule

// File: tb/tb_car_sequencer.sv
// Directed bench for car_sequencer: walks every chain kind, jumps, ILL, stall, interrupt and reset.
module tb_car_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [15:0] MDB;
  logic [3:0]  flags_nxt;
  logic        INT;
  logic        GIE;
  logic [5:0]  CAR;
  logic        decode_pt;
  logic        ILL;

  int checks;
  int errors;

  car_sequencer #(.CAR_BITS(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .MDB       (MDB),
    .flags_nxt (flags_nxt),
    .INT       (INT),
    .GIE       (GIE),
    .CAR       (CAR),
    .decode_pt (decode_pt),
    .ILL       (ILL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [5:0] exp_car, input logic exp_ill);
    checks++;
    assert (CAR === exp_car && ILL === exp_ill) else begin
      errors++;
      $error("FAIL %s observed CAR=%0d ILL=%b expected CAR=%0d ILL=%b",
             tag, CAR, ILL, exp_car, exp_ill);
    end
  endtask

  task automatic chk_dp(input string tag, input logic exp_dp);
    checks++;
    assert (decode_pt === exp_dp) else begin
      errors++;
      $error("FAIL %s observed decode_pt=%b expected %b", tag, decode_pt, exp_dp);
    end
  endtask

  // Advance one clock and check CAR/ILL shortly after the edge.
  task automatic cyc(input string tag, input logic [5:0] exp_car, input logic exp_ill = 1'b0);
    @(posedge clk);
    #1;
    chk(tag, exp_car, exp_ill);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    stall     = 1'b0;
    MDB       = 16'h0000;
    flags_nxt = 4'b0000;
    INT       = 1'b0;
    GIE       = 1'b0;
    #12;
    chk("reset", 6'd0, 1'b0);
    chk_dp("reset_dp", 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // MOV R5,R6 then an indexed-to-indexed move
    MDB = 16'h4506;
    cyc("mov_reg_reg", 6'd1);
    chk_dp("reg_reg_dp", 1'b1);
    MDB = 16'h4596;
    cyc("idx_idx0", 6'd16);
    cyc("idx_idx1", 6'd17);
    chk_dp("idx_idx1_dp", 1'b0);
    cyc("idx_idx2", 6'd18);
    cyc("idx_idx3", 6'd19);
    cyc("idx_idx4", 6'd20);
    cyc("idx_idx5", 6'd21);
    chk_dp("idx_idx5_dp", 1'b1);

    // JEQ taken / not taken, JL taken, JNC, JGE, JMP
    MDB = 16'h2400; flags_nxt = 4'b0010;
    cyc("jeq_taken", 6'd59);
    flags_nxt = 4'b0000;
    cyc("jmp0_ret", 6'd0);
    cyc("jeq_not_taken", 6'd0);
    MDB = 16'h3800; flags_nxt = 4'b0100;
    cyc("jl_taken", 6'd59);
    cyc("jl_ret", 6'd0);
    MDB = 16'h3800; flags_nxt = 4'b1100;
    cyc("jl_not_taken", 6'd0);
    MDB = 16'h2800; flags_nxt = 4'b0001;
    cyc("jnc_not_taken", 6'd0);
    MDB = 16'h3400; flags_nxt = 4'b1100;
    cyc("jge_taken", 6'd59);
    MDB = 16'h3C00; flags_nxt = 4'b0000;
    cyc("jmp0_ret2", 6'd0);
    cyc("jmp_always", 6'd59);
    cyc("jmp_always_ret", 6'd0);

    // PUSH R5, then CALL #imm, then RETI
    MDB = 16'h1205;
    cyc("push_reg0", 6'd30);
    cyc("push_reg1", 6'd31);
    cyc("push_reg2", 6'd32);
    MDB = 16'h12B0;
    cyc("call_ind0", 6'd43);
    cyc("call_ind1", 6'd44);
    cyc("call_ind2", 6'd45);
    cyc("call_ind_ret", 6'd0);
    MDB = 16'h1300;
    cyc("reti0", 6'd50);
    cyc("reti1", 6'd51);
    cyc("reti2", 6'd52);
    cyc("reti3", 6'd53);
    cyc("reti_ret", 6'd0);

    // Format II single-operand: RRC R5, then RRC x(R5)
    MDB = 16'h1005;
    cyc("1op_reg", 6'd22);
    MDB = 16'h1015;
    cyc("1op_idx0", 6'd26);
    cyc("1op_idx1", 6'd27);
    cyc("1op_idx2", 6'd28);
    cyc("1op_idx3", 6'd29);

    // Constant generator #4 via r2, then indirect source
    MDB = 16'h4226;
    cyc("cg_r2_reg", 6'd1);
    MDB = 16'h4526;
    cyc("ind_reg0", 6'd6);
    cyc("ind_reg1", 6'd7);

    // Illegal opcode: ILL one cycle only
    MDB = 16'h0000;
    cyc("ill_decode", 6'd0, 1'b1);
    MDB = 16'h4506;
    cyc("ill_clear", 6'd1, 1'b0);
    MDB = 16'h1380;
    cyc("ill_fmt2", 6'd0, 1'b1);
    // ILL held while stalled
    stall = 1'b1;
    cyc("ill_stall_hold", 6'd0, 1'b1);
    stall = 1'b0; MDB = 16'h4506;
    cyc("ill_stall_release", 6'd1, 1'b0);

    // Interrupt raised during IDX_REG0
    MDB = 16'h4516;
    cyc("idx_reg0", 6'd13);
    INT = 1'b1; GIE = 1'b1; MDB = 16'h4506;
    cyc("idx_reg1_int", 6'd14);
    cyc("idx_reg2_int", 6'd15);
`ifdef CAR_SEQ_INT_EN
    cyc("int0", 6'd54);
    INT = 1'b0;
    cyc("int1", 6'd55);
    cyc("int2", 6'd56);
    cyc("int3", 6'd57);
    cyc("int4", 6'd58);
    cyc("int_ret", 6'd0);
    MDB = 16'h4506;
    cyc("after_int", 6'd1);
`else
    cyc("int_ignored", 6'd1);
    INT = 1'b0;
`endif
    // Same request with GIE clear decodes normally
    MDB = 16'h4516;
    cyc("gie0_idx_reg0", 6'd13);
    INT = 1'b1; GIE = 1'b0; MDB = 16'h4506;
    cyc("gie0_idx_reg1", 6'd14);
    cyc("gie0_idx_reg2", 6'd15);
    cyc("gie0_decode", 6'd1);
    INT = 1'b0;

    // Stall three cycles at IND_IDX1
    MDB = 16'h45A6;
    cyc("ind_idx0", 6'd8);
    cyc("ind_idx1", 6'd9);
    stall = 1'b1;
    cyc("stall_a", 6'd9);
    cyc("stall_b", 6'd9);
    cyc("stall_c", 6'd9);
    stall = 1'b0;
    cyc("ind_idx2", 6'd10);
    cyc("ind_idx3", 6'd11);
    cyc("ind_idx4", 6'd12);
    // Stall at a decode point defers decode; MDB is resampled on release
    stall = 1'b1; MDB = 16'h0000;
    cyc("dp_stall", 6'd12);
    stall = 1'b0; MDB = 16'h4506;
    cyc("dp_stall_release", 6'd1);

    // Asynchronous reset mid-chain at IDX_IDX3
    MDB = 16'h4596;
    cyc("rst_idx_idx0", 6'd16);
    cyc("rst_idx_idx1", 6'd17);
    cyc("rst_idx_idx2", 6'd18);
    cyc("rst_idx_idx3", 6'd19);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 6'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    MDB = 16'h4506;
    cyc("post_reset", 6'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
